// File: rtl/custom_axi_ip_pkg.sv
// Shared types for the multi-channel register-to-hardware processing engine.
package custom_axi_ip_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        BUSY  = 2'b01,
        DONE  = 2'b10,
        ERROR = 2'b11
    } status_e;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_XOR  = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

    // Channel index width, never narrower than one bit.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/custom_axi_ip_rr_arb.sv
// Round-robin arbiter: picks the first requesting channel after the previous winner.
module custom_axi_ip_rr_arb
    import custom_axi_ip_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CH_W   = ch_width(NUM_CH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NUM_CH-1:0] req_i,
    input  logic              advance_i,
    output logic [CH_W-1:0]   gnt_idx_o,
    output logic              gnt_valid_o
);

    logic [CH_W-1:0] r_last;
    logic [CH_W-1:0] w_cand;
    logic            w_found;

    // rotating-priority scan starting one past the last winner
    always_comb begin
        gnt_idx_o = {CH_W{1'b0}};
        w_found   = 1'b0;
        w_cand    = {CH_W{1'b0}};
        for (int i = 1; i <= NUM_CH; i++) begin
            w_cand = CH_W'((int'(r_last) + i) % NUM_CH);
            if (!w_found && req_i[w_cand]) begin
                gnt_idx_o = w_cand;
                w_found   = 1'b1;
            end else begin
                w_found = w_found;
            end
        end
        gnt_valid_o = w_found;
    end

    // remember the most recent winner
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_last <= {CH_W{1'b0}};
        end else if (advance_i) begin
            r_last <= gnt_idx_o;
        end else begin
            r_last <= r_last;
        end
    end

endmodule

// File: rtl/custom_axi_ip_engine.sv
// Multi-channel processing engine: queues one request per channel and serves them
// round-robin through a shared IDLE/BUSY/DONE/ERROR job FSM.
module custom_axi_ip_engine
    import custom_axi_ip_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 4,
    parameter int ITER_W     = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NUM_CH*DATA_WIDTH-1:0] ipreg_data_i,
    input  logic [NUM_CH-1:0]            enable_i,
    input  logic [1:0]                   op_i,
    input  logic [DATA_WIDTH-1:0]        operand_i,
    input  logic [ITER_W-1:0]            iter_i,
    input  logic                         clear_i,
    output logic [DATA_WIDTH-1:0]        ipreg_data_o,
    output logic [ch_width(NUM_CH)-1:0]  ch_o,
    output logic                         wen_o,
    output logic                         ovf_o,
    output status_e                      status_o,
    output logic [NUM_CH-1:0]            pending_o,
    output logic [NUM_CH-1:0]            overrun_o
);

    localparam int CH_W = ch_width(NUM_CH);

    status_e               r_state;
    op_e                   r_op;
    logic [DATA_WIDTH-1:0] r_acc;
    logic [DATA_WIDTH-1:0] r_operand;
    logic [ITER_W-1:0]     r_cnt;
    logic                  r_ovf;
    logic [NUM_CH-1:0]     r_pending;
    logic [NUM_CH-1:0]     r_overrun;
    logic [DATA_WIDTH-1:0] r_data [NUM_CH];
    logic [CH_W-1:0]       r_ch;
    logic                  r_wen;
    logic                  r_ovf_o;
    logic [DATA_WIDTH-1:0] r_dout;

    logic [CH_W-1:0]       w_gnt_idx;
    logic                  w_gnt_valid;
    logic                  w_grant;
    logic [NUM_CH-1:0]     w_gnt_vec;
    logic [NUM_CH-1:0]     w_drop;
    logic [DATA_WIDTH:0]   w_alu;

    // Result carries the ADD carry-out / SUB borrow in its top bit.
    function automatic logic [DATA_WIDTH:0] alu_f(input op_e op,
                                                  input logic [DATA_WIDTH-1:0] a,
                                                  input logic [DATA_WIDTH-1:0] b);
        case (op)
            OP_ADD:  alu_f = {1'b0, a} + {1'b0, b};
            OP_SUB:  alu_f = {1'b0, a} - {1'b0, b};
            OP_XOR:  alu_f = {1'b0, a ^ b};
            default: alu_f = {1'b0, a};
        endcase
    endfunction

    custom_axi_ip_rr_arb #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_arb (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_i       (r_pending),
        .advance_i   (w_grant),
        .gnt_idx_o   (w_gnt_idx),
        .gnt_valid_o (w_gnt_valid)
    );

    // grant decode and request-drop detection
    always_comb begin
        w_grant              = (r_state == IDLE) && w_gnt_valid;
        w_gnt_vec            = {NUM_CH{1'b0}};
        w_gnt_vec[w_gnt_idx] = w_grant;
        w_drop               = enable_i & r_pending & ~w_gnt_vec;
        w_alu                = alu_f(r_op, r_acc, r_operand);
    end

    // request queue: a new request beats a same-edge grant, a repeat is dropped
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pending <= {NUM_CH{1'b0}};
            r_overrun <= {NUM_CH{1'b0}};
            for (int c = 0; c < NUM_CH; c++) begin
                r_data[c] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            r_pending <= (r_pending & ~w_gnt_vec) | enable_i;
            r_overrun <= (clear_i ? {NUM_CH{1'b0}} : r_overrun) | w_drop;
            for (int c = 0; c < NUM_CH; c++) begin
                if (enable_i[c] && !w_drop[c]) begin
                    r_data[c] <= ipreg_data_i[c*DATA_WIDTH +: DATA_WIDTH];
                end else begin
                    r_data[c] <= r_data[c];
                end
            end
        end
    end

    // job FSM with accumulator/counter datapath and registered result outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_op      <= OP_ADD;
            r_acc     <= {DATA_WIDTH{1'b0}};
            r_operand <= {DATA_WIDTH{1'b0}};
            r_cnt     <= {ITER_W{1'b0}};
            r_ovf     <= 1'b0;
            r_ch      <= {CH_W{1'b0}};
            r_wen     <= 1'b0;
            r_ovf_o   <= 1'b0;
            r_dout    <= {DATA_WIDTH{1'b0}};
        end else begin
            r_wen <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_gnt_valid) begin
                        r_acc     <= r_data[w_gnt_idx];
                        r_op      <= op_e'(op_i);
                        r_operand <= operand_i;
                        r_cnt     <= iter_i;
                        r_ovf     <= 1'b0;
                        r_ch      <= w_gnt_idx;
                        if (op_e'(op_i) == OP_RSVD) begin
                            r_state <= ERROR;
                        end else if (iter_i == {ITER_W{1'b0}}) begin
                            r_state <= DONE;
                        end else begin
                            r_state <= BUSY;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
                BUSY: begin
                    r_acc <= w_alu[DATA_WIDTH-1:0];
                    r_ovf <= r_ovf | w_alu[DATA_WIDTH];
                    r_cnt <= r_cnt - ITER_W'(1);
                    if (r_cnt == ITER_W'(1)) begin
                        r_state <= DONE;
                    end else begin
                        r_state <= BUSY;
                    end
                end
                DONE: begin
                    r_wen   <= 1'b1;
                    r_dout  <= r_acc;
                    r_ovf_o <= r_ovf;
                    r_state <= IDLE;
                end
                ERROR: begin
                    if (clear_i) begin
                        r_state <= IDLE;
                    end else begin
                        r_state <= ERROR;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ipreg_data_o = r_dout;
    assign ch_o         = r_ch;
    assign wen_o        = r_wen;
    assign ovf_o        = r_ovf_o;
    assign status_o     = r_state;
    assign pending_o    = r_pending;
    assign overrun_o    = r_overrun;

endmodule

// File: tb/tb_custom_axi_ip_engine.sv
// Directed self-checking bench for custom_axi_ip_engine (NUM_CH=4, DATA_WIDTH=32).
module tb_custom_axi_ip_engine;
    import custom_axi_ip_pkg::*;

    logic         clk;
    logic         rst_i;
    logic [127:0] ipreg_data_i;
    logic [3:0]   enable_i;
    logic [1:0]   op_i;
    logic [31:0]  operand_i;
    logic [3:0]   iter_i;
    logic         clear_i;
    logic [31:0]  ipreg_data_o;
    logic [1:0]   ch_o;
    logic         wen_o;
    logic         ovf_o;
    status_e      status_o;
    logic [3:0]   pending_o;
    logic [3:0]   overrun_o;

    int n_vec = 0;
    int n_err = 0;
    int lat;
    logic seen;

    custom_axi_ip_engine #(
        .DATA_WIDTH (32),
        .NUM_CH     (4),
        .ITER_W     (4)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .ipreg_data_i (ipreg_data_i),
        .enable_i     (enable_i),
        .op_i         (op_i),
        .operand_i    (operand_i),
        .iter_i       (iter_i),
        .clear_i      (clear_i),
        .ipreg_data_o (ipreg_data_o),
        .ch_o         (ch_o),
        .wen_o        (wen_o),
        .ovf_o        (ovf_o),
        .status_o     (status_o),
        .pending_o    (pending_o),
        .overrun_o    (overrun_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_data(input int c, input logic [31:0] v);
        ipreg_data_i[c*32 +: 32] = v;
    endtask

    task automatic cfg(input logic [1:0] op, input logic [31:0] opnd, input logic [3:0] it);
        op_i      = op;
        operand_i = opnd;
        iter_i    = it;
    endtask

    task automatic send(input logic [3:0] m);
        enable_i = m;
        @(negedge clk);
        enable_i = 4'b0000;
    endtask

    // lat counts negedges since the enable was driven; bounded wait
    task automatic wait_wen(output int l);
        l = 1;
        while (!wen_o && l < 60) begin
            @(negedge clk);
            l++;
        end
        chk("wen_seen", {63'd0, wen_o}, 64'd1);
    endtask

    task automatic check_result(input string tag, input logic [1:0] c,
                                input logic [31:0] d, input logic v);
        chk({tag, "_ch"},   {62'd0, ch_o}, {62'd0, c});
        chk({tag, "_data"}, {32'd0, ipreg_data_o}, {32'd0, d});
        chk({tag, "_ovf"},  {63'd0, ovf_o}, {63'd0, v});
        @(negedge clk);
        chk({tag, "_wen_1cyc"}, {63'd0, wen_o}, 64'd0);
    endtask

    initial begin
        rst_i        = 1'b1;
        ipreg_data_i = 128'd0;
        enable_i     = 4'b0000;
        clear_i      = 1'b0;
        cfg(2'b00, 32'd0, 4'd0);
        repeat (2) @(negedge clk);
        chk("rst_status",  {62'd0, status_o}, {62'd0, IDLE});
        chk("rst_wen",     {63'd0, wen_o}, 64'd0);
        chk("rst_pending", {60'd0, pending_o}, 64'd0);
        chk("rst_data",    {32'd0, ipreg_data_o}, 64'd0);
        rst_i = 1'b0;
        @(negedge clk);

        // 1: 0x10 + 3 + 3
        set_data(1, 32'h0000_0010);
        cfg(2'b00, 32'd3, 4'd2);
        send(4'b0010);
        wait_wen(lat);
        chk("t1_latency", 64'(lat), 64'd5);
        chk("t1_status",  {62'd0, status_o}, {62'd0, IDLE});
        check_result("t1", 2'd1, 32'h0000_0016, 1'b0);

        // 2: ADD carry, SUB borrow, XOR without carry
        set_data(0, 32'hFFFF_FFFF);
        cfg(2'b00, 32'd1, 4'd1);
        send(4'b0001);
        wait_wen(lat);
        chk("t2_latency", 64'(lat), 64'd4);
        check_result("t2add", 2'd0, 32'h0000_0000, 1'b1);
        set_data(0, 32'h0000_0000);
        cfg(2'b01, 32'd1, 4'd1);
        send(4'b0001);
        wait_wen(lat);
        check_result("t2sub", 2'd0, 32'hFFFF_FFFF, 1'b1);
        set_data(3, 32'hA5A5_0000);
        cfg(2'b10, 32'h0000_FFFF, 4'd3);
        send(4'b1000);
        wait_wen(lat);
        check_result("t2xor", 2'd3, 32'hA5A5_FFFF, 1'b0);

        // 3: four pass-through requests at once, last grant was ch3
        for (int c = 0; c < 4; c++) set_data(c, 32'h1000 + 32'(c));
        cfg(2'b00, 32'h55, 4'd0);
        send(4'b1111);
        for (int i = 0; i < 4; i++) begin
            wait_wen(lat);
            if (i == 0) chk("t3_latency", 64'(lat), 64'd3);
            check_result($sformatf("t3a_%0d", i), 2'(i), 32'h1000 + 32'(i), 1'b0);
        end
        set_data(1, 32'h0000_BEEF);
        send(4'b0010);
        wait_wen(lat);
        check_result("t3_single", 2'd1, 32'h0000_BEEF, 1'b0);
        for (int c = 0; c < 4; c++) set_data(c, 32'h2000 + 32'(c));
        send(4'b1111);
        for (int i = 0; i < 4; i++) begin
            wait_wen(lat);
            check_result($sformatf("t3b_%0d", i), 2'((i + 2) % 4),
                         32'h2000 + 32'((i + 2) % 4), 1'b0);
        end

        // 4: repeat request on a queued channel while engine is busy
        cfg(2'b00, 32'd1, 4'd5);
        set_data(1, 32'h200);
        set_data(2, 32'h300);
        enable_i = 4'b0010;
        @(negedge clk);
        enable_i = 4'b0100;
        @(negedge clk);
        set_data(2, 32'h999);
        enable_i = 4'b0100;
        @(negedge clk);
        enable_i = 4'b0000;
        chk("t4_overrun", {60'd0, overrun_o}, 64'h4);
        chk("t4_pending", {60'd0, pending_o}, 64'h4);
        chk("t4_busy",    {62'd0, status_o}, {62'd0, BUSY});
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
        chk("t4_clear", {60'd0, overrun_o}, 64'd0);
        wait_wen(lat);
        check_result("t4_ch1", 2'd1, 32'h205, 1'b0);
        wait_wen(lat);
        check_result("t4_ch2", 2'd2, 32'h305, 1'b0);

        // 5: reserved op on ch3 parks the engine in ERROR, ch0 stays queued
        cfg(2'b11, 32'd0, 4'd1);
        set_data(0, 32'h40);
        set_data(3, 32'h77);
        send(4'b1001);
        @(negedge clk);
        chk("t5_error",   {62'd0, status_o}, {62'd0, ERROR});
        chk("t5_pending", {60'd0, pending_o}, 64'h1);
        chk("t5_ch",      {62'd0, ch_o}, 64'd3);
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            seen = seen | wen_o;
        end
        chk("t5_no_wen",  {63'd0, seen}, 64'd0);
        chk("t5_held",    {62'd0, status_o}, {62'd0, ERROR});
        cfg(2'b00, 32'd7, 4'd1);
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
        chk("t5_idle",     {62'd0, status_o}, {62'd0, IDLE});
        chk("t5_pending2", {60'd0, pending_o}, 64'h1);
        wait_wen(lat);
        check_result("t5_ch0", 2'd0, 32'h47, 1'b0);

        // 6: reset in the middle of a long job
        cfg(2'b00, 32'd1, 4'd10);
        set_data(1, 32'd5);
        send(4'b0010);
        repeat (3) @(negedge clk);
        chk("t6_busy", {62'd0, status_o}, {62'd0, BUSY});
        send(4'b0100);
        chk("t6_pend", {60'd0, pending_o}, 64'h4);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        chk("t6_status",  {62'd0, status_o}, {62'd0, IDLE});
        chk("t6_data",    {32'd0, ipreg_data_o}, 64'd0);
        chk("t6_ch",      {62'd0, ch_o}, 64'd0);
        chk("t6_wen",     {63'd0, wen_o}, 64'd0);
        chk("t6_ovf",     {63'd0, ovf_o}, 64'd0);
        chk("t6_pending", {60'd0, pending_o}, 64'd0);
        chk("t6_overrun", {60'd0, overrun_o}, 64'd0);
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            seen = seen | wen_o;
        end
        chk("t6_no_wen", {63'd0, seen}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
